// File: rtl/updn_counter.sv
// Up/down counter with load, wrap or saturate at the range limits,
// sticky overflow/underflow flags and a record of the last operation.
module updn_counter #(
    parameter int WIDTH    = 8,
    parameter int SAT_MODE = 0
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             ld_cnt_,
    input  logic             updn_cnt,
    input  logic             count_enb,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] data_out,
    output logic             tc,
    output logic             ovf,
    output logic             unf,
    output logic [2:0]       op_state
);

    typedef enum logic [2:0] {
        ST_RST  = 3'd0,
        ST_LOAD = 3'd1,
        ST_UP   = 3'd2,
        ST_DOWN = 3'd3,
        ST_HOLD = 3'd4,
        ST_SAT  = 3'd5
    } op_e;

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    op_e              op_q, op_d;
    logic             at_limit;

    // Next count, flags and operation record; load beats count beats hold.
    always_comb begin
        at_limit = updn_cnt ? (cnt_q == CNT_MAX) : (cnt_q == '0);
        tc       = rst_ & ld_cnt_ & count_enb & at_limit;
        cnt_d    = cnt_q;
        op_d     = ST_HOLD;
        // Clear first so a same-edge set condition overrides it.
        ovf_d    = clr_flags ? 1'b0 : ovf_q;
        unf_d    = clr_flags ? 1'b0 : unf_q;
        if (!ld_cnt_) begin
            cnt_d = data_in;
            op_d  = ST_LOAD;
        end else if (count_enb) begin
            if (at_limit) begin
                if (updn_cnt) ovf_d = 1'b1;
                else          unf_d = 1'b1;
            end
            if (at_limit && (SAT_MODE != 0)) begin
                op_d = ST_SAT;
            end else begin
                cnt_d = updn_cnt ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
                op_d  = updn_cnt ? ST_UP : ST_DOWN;
            end
        end
        // Encodings 6/7 can only appear through a state upset; park in HOLD.
        if (op_q > ST_SAT) op_d = ST_HOLD;
    end

    // State registers; reset forces everything to zero immediately.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            op_q  <= ST_RST;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            op_q  <= op_d;
        end
    end

    assign data_out = cnt_q;
    assign ovf      = ovf_q;
    assign unf      = unf_q;
    assign op_state = op_q;

endmodule

// File: tb/tb_updn_counter.sv
// Bench for updn_counter: a wrapping (index 0) and a saturating (index 1)
// instance share stimulus; an arithmetic model is compared every cycle.
module tb_updn_counter;

    logic       clk = 1'b0;
    logic       rst_ = 1'b0;
    logic       ld_cnt_ = 1'b1;
    logic       updn_cnt = 1'b1;
    logic       count_enb = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       clr_flags = 1'b0;

    logic [7:0] dout [2];
    logic       tc   [2];
    logic       ovf  [2];
    logic       unf  [2];
    logic [2:0] ops  [2];

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    int m_cnt [2] = '{0, 0};
    int m_ovf [2] = '{0, 0};
    int m_unf [2] = '{0, 0};
    int m_op  [2] = '{0, 0};

    always #5 clk = ~clk;

    updn_counter #(.WIDTH(8), .SAT_MODE(0)) u_wrap (
        .clk(clk), .rst_(rst_), .ld_cnt_(ld_cnt_), .updn_cnt(updn_cnt),
        .count_enb(count_enb), .data_in(data_in), .clr_flags(clr_flags),
        .data_out(dout[0]), .tc(tc[0]), .ovf(ovf[0]), .unf(unf[0]), .op_state(ops[0])
    );

    updn_counter #(.WIDTH(8), .SAT_MODE(1)) u_sat (
        .clk(clk), .rst_(rst_), .ld_cnt_(ld_cnt_), .updn_cnt(updn_cnt),
        .count_enb(count_enb), .data_in(data_in), .clr_flags(clr_flags),
        .data_out(dout[1]), .tc(tc[1]), .ovf(ovf[1]), .unf(unf[1]), .op_state(ops[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: plain integer arithmetic, out-of-range result means a limit hit.
    always @(posedge clk or negedge rst_) begin
        for (int s = 0; s < 2; s++) begin
            int n, fo, fu;
            if (!rst_) begin
                m_cnt[s] <= 0; m_ovf[s] <= 0; m_unf[s] <= 0; m_op[s] <= 0;
            end else begin
                fo = clr_flags ? 0 : m_ovf[s];
                fu = clr_flags ? 0 : m_unf[s];
                if (!ld_cnt_) begin
                    m_cnt[s] <= int'(data_in);
                    m_op[s]  <= 1;
                end else if (count_enb) begin
                    n = m_cnt[s] + (updn_cnt ? 1 : -1);
                    if (n > 255 || n < 0) begin
                        if (updn_cnt) fo = 1; else fu = 1;
                        if (s == 1) begin
                            m_op[s] <= 5;
                        end else begin
                            m_cnt[s] <= (n + 256) % 256;
                            m_op[s]  <= updn_cnt ? 2 : 3;
                        end
                    end else begin
                        m_cnt[s] <= n;
                        m_op[s]  <= updn_cnt ? 2 : 3;
                    end
                end else begin
                    m_op[s] <= 4;
                end
                m_ovf[s] <= fo;
                m_unf[s] <= fu;
            end
        end
    end

    // Every-cycle compare of both instances against the model.
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            int etc;
            etc = (rst_ && ld_cnt_ && count_enb &&
                   (updn_cnt ? (m_cnt[s] == 255) : (m_cnt[s] == 0))) ? 1 : 0;
            chk($sformatf("cyc data_out[%0d]", s), 32'(dout[s]), 32'(m_cnt[s]));
            chk($sformatf("cyc tc[%0d]", s),       32'(tc[s]),   32'(etc));
            chk($sformatf("cyc ovf[%0d]", s),      32'(ovf[s]),  32'(m_ovf[s]));
            chk($sformatf("cyc unf[%0d]", s),      32'(unf[s]),  32'(m_unf[s]));
            chk($sformatf("cyc op[%0d]", s),       32'(ops[s]),  32'(m_op[s]));
        end
    end

    // Apply one input vector away from the edge, then return just after the edge.
    task automatic cyc(input logic ld, input logic up, input logic en,
                       input logic [7:0] din, input logic clr);
        @(negedge clk); #2;
        ld_cnt_ = ld; updn_cnt = up; count_enb = en; data_in = din; clr_flags = clr;
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset data_out", 32'(dout[0]), 32'h0);
        chk("reset op", 32'(ops[0]), 32'h0);
        @(negedge clk); #2; rst_ = 1'b1;

        // load 5A, then reset mid-cycle
        cyc(1'b0, 1'b1, 1'b1, 8'h5A, 1'b0);
        chk("load 5A", 32'(dout[0]), 32'h5A);
        #2; rst_ = 1'b0; #1;
        chk("async rst data_out", 32'(dout[0]), 32'h0);
        chk("async rst op", 32'(ops[0]), 32'h0);
        chk("async rst ovf", 32'(ovf[0]), 32'h0);
        cyc(1'b0, 1'b1, 1'b1, 8'h77, 1'b0);
        chk("edge in rst data_out", 32'(dout[1]), 32'h0);
        chk("edge in rst tc", 32'(tc[1]), 32'h0);
        @(negedge clk); #2; rst_ = 1'b1;

        // load FE with count_enb high; count up through the wrap
        cyc(1'b0, 1'b0, 1'b1, 8'hFE, 1'b0);
        chk("load FE", 32'(dout[0]), 32'hFE);
        chk("load op", 32'(ops[0]), 32'h1);
        cyc(1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
        chk("up FF", 32'(dout[0]), 32'hFF);
        chk("tc at FF", 32'(tc[0]), 32'h1);
        chk("no ovf yet", 32'(ovf[0]), 32'h0);
        cyc(1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
        chk("wrap 00", 32'(dout[0]), 32'h00);
        chk("ovf on wrap", 32'(ovf[0]), 32'h1);
        chk("sat stays FF", 32'(dout[1]), 32'hFF);
        chk("sat op SAT", 32'(ops[1]), 32'h5);
        chk("sat ovf", 32'(ovf[1]), 32'h1);
        cyc(1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
        chk("up 01", 32'(dout[0]), 32'h01);
        chk("ovf sticky", 32'(ovf[0]), 32'h1);

        // saturating down-count from 01
        cyc(1'b0, 1'b0, 1'b0, 8'h01, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        chk("sat dn 00", 32'(dout[1]), 32'h00);
        chk("sat dn op", 32'(ops[1]), 32'h3);
        cyc(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        chk("sat dn hold 00", 32'(dout[1]), 32'h00);
        chk("sat dn op SAT", 32'(ops[1]), 32'h5);
        chk("sat unf", 32'(unf[1]), 32'h1);
        chk("wrap dn FF", 32'(dout[0]), 32'hFF);

        // hold at 37 for 5 edges
        cyc(1'b0, 1'b1, 1'b1, 8'h37, 1'b0);
        repeat (5) cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("hold 37", 32'(dout[0]), 32'h37);
        chk("hold op", 32'(ops[0]), 32'h4);

        // clear flags, then clear racing an overflow
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("clr ovf", 32'(ovf[0]), 32'h0);
        chk("clr unf", 32'(unf[0]), 32'h0);
        cyc(1'b0, 1'b1, 1'b1, 8'hFF, 1'b0);
        chk("load keeps ovf", 32'(ovf[0]), 32'h0);
        cyc(1'b1, 1'b1, 1'b1, 8'h00, 1'b1);
        chk("set beats clr", 32'(ovf[0]), 32'h1);
        cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        chk("idle clr", 32'(ovf[0]), 32'h0);

        // mixed traffic checked by the per-cycle compare only
        for (int i = 0; i < 60; i++) begin
            cyc(($urandom_range(0, 7) != 0), $urandom_range(0, 1) != 0,
                $urandom_range(0, 3) != 0, 8'($urandom_range(0, 3) * 85),
                $urandom_range(0, 5) == 0);
        end

        @(negedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
